// File: rtl/alu_issue_queue.sv
// Issue queue in front of a combinational 32-bit ALU: FIFO-buffered requests, one issue per cycle,
// registered result slot with valid/ready and a sequence tag. Optional same-cycle bypass: ALU_ISSUE_BYPASS_EN.
module alu_issue_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_opcode,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    output logic                     alu_en,
    output logic [2:0]               alu_opcode,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic [2:0]               out_opcode,
    output logic [TAG_W-1:0]         out_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_RUN     = 2'd1,
        ST_BLOCKED = 2'd2
    } state_e;

    logic [2:0]        op_mem_q [DEPTH];
    logic [DATA_W-1:0] a_mem_q  [DEPTH];
    logic [DATA_W-1:0] b_mem_q  [DEPTH];

    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [TAG_W-1:0]  tag_q;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q;
    logic [2:0]        out_opcode_q;
    logic [TAG_W-1:0]  out_tag_q;
    state_e            state_q, state_d;

    logic fifo_empty_s, slot_free_s, push_s, issue_fifo_s, bypass_s, issue_s;

    assign fifo_empty_s = (count_q == {CW{1'b0}});
    assign slot_free_s  = !out_valid_q || out_ready;
    // in_ready looks only at occupancy, so a full FIFO refuses input even on a popping cycle.
    assign in_ready     = (count_q < CW'(DEPTH));
    assign issue_fifo_s = !fifo_empty_s && slot_free_s;

`ifdef ALU_ISSUE_BYPASS_EN
    assign bypass_s = fifo_empty_s && in_valid && slot_free_s;
`else
    assign bypass_s = 1'b0;
`endif

    assign issue_s = issue_fifo_s || bypass_s;
    assign push_s  = in_valid && in_ready && !bypass_s;

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_opcode = out_opcode_q;
    assign out_tag    = out_tag_q;
    assign count      = count_q;

    // ALU drive: FIFO head, bypassed input, or all-zero when idle.
    always_comb begin
        alu_en     = 1'b0;
        alu_opcode = 3'd0;
        alu_a      = {DATA_W{1'b0}};
        alu_b      = {DATA_W{1'b0}};
        if (issue_fifo_s) begin
            alu_en     = 1'b1;
            alu_opcode = op_mem_q[rd_ptr_q];
            alu_a      = a_mem_q[rd_ptr_q];
            alu_b      = b_mem_q[rd_ptr_q];
        end else if (bypass_s) begin
            alu_en     = 1'b1;
            alu_opcode = in_opcode;
            alu_a      = in_a;
            alu_b      = in_b;
        end else begin
            alu_en     = 1'b0;
        end
    end

    // Next occupancy and result-slot valid.
    always_comb begin
        count_d     = count_q;
        out_valid_d = out_valid_q;
        case ({push_s, issue_fifo_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (issue_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Status classification from the post-edge occupancy and slot state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY, ST_RUN, ST_BLOCKED: begin
                if ((count_d == {CW{1'b0}}) && !out_valid_d) begin
                    state_d = ST_EMPTY;
                end else if (out_valid_d && !out_ready && (count_d != {CW{1'b0}})) begin
                    state_d = ST_BLOCKED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Status state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem_q[i] <= 3'd0;
                a_mem_q[i]  <= {DATA_W{1'b0}};
                b_mem_q[i]  <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                op_mem_q[wr_ptr_q] <= in_opcode;
                a_mem_q[wr_ptr_q]  <= in_a;
                b_mem_q[wr_ptr_q]  <= in_b;
                wr_ptr_q           <= wr_ptr_q + AW'(1);
            end
            if (issue_fifo_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Result slot capture and tag counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= {DATA_W{1'b0}};
            out_opcode_q <= 3'd0;
            out_tag_q    <= {TAG_W{1'b0}};
            tag_q        <= {TAG_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            if (issue_s) begin
                out_result_q <= alu_result;
                out_opcode_q <= alu_opcode;
                out_tag_q    <= tag_q;
                tag_q        <= tag_q + TAG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue against a queue-based transaction model.
module tb_alu_issue_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 8;

    logic              clk, rst_n;
    logic              in_valid, in_ready;
    logic [2:0]        in_opcode;
    logic [DATA_W-1:0] in_a, in_b;
    logic              alu_en;
    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_result;
    logic [2:0]        out_opcode;
    logic [TAG_W-1:0]  out_tag;
    logic [2:0]        count;

    alu_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_opcode(out_opcode), .out_tag(out_tag), .count(count)
    );

    // Stub ALU.
    assign alu_result = alu_a + alu_b + {29'd0, alu_opcode};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t        mq[$];
    logic        s_v;
    logic [31:0] s_res;
    logic [2:0]  s_op;
    logic [7:0]  s_tag;
    logic [7:0]  m_tag;
    logic [31:0] exp_state;   // 0 EMPTY, 1 RUN, 2 BLOCKED
    int          n_checks, n_pass;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        s_v = 1'b0; s_res = 32'd0; s_op = 3'd0; s_tag = 8'd0; m_tag = 8'd0; exp_state = 32'd0;
    endtask

    // One clock cycle: drive, check against the model, advance the model, step past the edge.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rdy);
        req_t h;
        logic fifo_iss, byp, iss, acc;
        in_valid = v; in_opcode = op; in_a = a; in_b = b; out_ready = rdy;
        #1;
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check_eq("out_valid", 32'(out_valid), 32'(s_v));
        check_eq("out_result", out_result, s_res);
        check_eq("out_opcode", 32'(out_opcode), 32'(s_op));
        check_eq("out_tag", 32'(out_tag), 32'(s_tag));
        check_eq("fsm", 32'(dut.state_q), exp_state);
        acc      = v && (mq.size() < DEPTH);
        fifo_iss = (mq.size() != 0) && (!s_v || rdy);
        byp      = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
        byp      = (mq.size() == 0) && v && (!s_v || rdy);
`endif
        iss = fifo_iss || byp;
        if (fifo_iss)  h = mq[0];
        else if (byp)  h = '{op, a, b};
        else           h = '{3'd0, 32'd0, 32'd0};
        check_eq("alu_en", 32'(alu_en), 32'(iss));
        check_eq("alu_opcode", 32'(alu_opcode), 32'(h.op));
        check_eq("alu_a", alu_a, h.a);
        check_eq("alu_b", alu_b, h.b);
        if (iss) begin
            s_v = 1'b1; s_res = h.a + h.b + 32'(h.op); s_op = h.op; s_tag = m_tag;
            m_tag = m_tag + 8'd1;
            if (fifo_iss) void'(mq.pop_front());
        end else if (rdy) begin
            s_v = 1'b0;
        end
        if (acc && !byp) mq.push_back('{op, a, b});
        if (mq.size() == 0 && !s_v)                exp_state = 32'd0;
        else if (s_v && !rdy && mq.size() != 0)    exp_state = 32'd2;
        else                                       exp_state = 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 3'd0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_alu_en", 32'(alu_en), 32'd0);
        check_eq("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_alu_b", alu_b, 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_result", out_result, 32'd0);
        check_eq("rst_out_opcode", 32'(out_opcode), 32'd0);
        check_eq("rst_out_tag", 32'(out_tag), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_fsm", 32'(dut.state_q), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First request: 6 + 5 + 0 = 11, tag 0.
        cycle(1'b1, 3'd0, 32'd6, 32'd5, 1'b1);
        idle(3);

        // Back-to-back opcodes 0..7.
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 32'd6, 32'd5, 1'b1);
        idle(3);

        // Fill with downstream stalled; the 6th push is refused.
        for (int i = 0; i < 6; i++) cycle(1'b1, 3'(i), 32'd100 + 32'(i), 32'd7, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        check_eq("full_fsm_blocked", 32'(dut.state_q), 32'd2);
        idle(8);

        // Same-edge push and pop at count 2.
        for (int i = 0; i < 3; i++) cycle(1'b1, 3'd1, 32'd10 + 32'(i), 32'd20, 1'b0);
        cycle(1'b1, 3'd7, 32'd1, 32'd1, 1'b1);
        idle(6);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, 3'($urandom), $urandom, $urandom, $urandom_range(0, 3) != 0);
        idle(8);

        // Reset mid-stream with count 3 and a pending result.
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 32'd50, 32'd60, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_count", 32'(count), 32'd0);
        check_eq("midrst_fsm", 32'(dut.state_q), 32'd0);
        check_eq("midrst_out_tag", 32'(out_tag), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tag wrap: 257 requests, tags 0..255 then 0.
        for (int i = 0; i < 257; i++) cycle(1'b1, 3'(i), 32'(i), 32'd3, 1'b1);
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream issue stage for the 32-bit combinational `alu`. It accepts operation requests (opcode, A, B) over a valid/ready handshake and buffers them in a small FIFO. It issues one request per cycle by driving the ALU's `En`/`opcode`/`A`/`B`, captures the ALU result into a registered output slot, and presents that result downstream with valid/ready and a sequence tag.

## Interface
- `DATA_W`, 32, operand/result width; matches `alu`.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TAG_W`, 8, width of issue sequence tag.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  FIFO can accept.
- `in_opcode`  in  3  ALU opcode.
- `in_a`, `in_b`  in  DATA_W  operands.
- `alu_en`  out  1  to `alu` `En`.
- `alu_opcode`  out  3  to `alu` `opcode`.
- `alu_a`, `alu_b`  out  DATA_W  to `alu` `A`/`B`.
- `alu_result`  in  DATA_W  from `alu` `result`; combinational, same cycle.
- `out_valid`  out  1  result slot full.
- `out_ready`  in  1  downstream accepts.
- `out_result`  out  DATA_W  captured result.
- `out_opcode`  out  3  opcode of captured result.
- `out_tag`  out  TAG_W  issue sequence number.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Push:** when `in_valid && in_ready` at a clock edge, write {opcode, a, b} at the write pointer.
  - `in_ready = (count < DEPTH)`, independent of a same-cycle pop. A full FIFO refuses input even while popping.
- **Issue condition:** `issue = (count != 0) && (!out_valid || out_ready)`.
  - When `issue` is high: `alu_en = 1`, `alu_opcode/a/b` = FIFO head.
  - At the edge:
    - `out_result <= alu_result`, `out_opcode <= head opcode`, `out_tag <= tag_cnt`, `out_valid <= 1`.
    - Pop the head; `tag_cnt <= tag_cnt + 1`, wrapping from 2^TAG_W−1 to 0.
- **Not issuing:** `alu_en = 0` and `alu_opcode/a/b = 0`, so the ALU inputs are quiet.
- **Drain:** `out_valid && out_ready` with no issue clears `out_valid`. With a same-edge issue, `out_valid` stays 1 and the slot takes the new data.
- **Stall:** while `out_valid && !out_ready`, all `out_*` hold and no issue occurs.
- **Simultaneous push and pop:** `count` is unchanged. Pointers wrap modulo DEPTH.
- **Status FSM**, registered, next state computed from post-edge `count`/`out_valid`/`out_ready`:
  - `EMPTY`: count=0, !out_valid.
  - `RUN`: issuing or draining.
  - `BLOCKED`: out_valid && !out_ready && count>0.
  - Transitions:
    - EMPTY→RUN on first push.
    - RUN→BLOCKED when downstream stalls with FIFO non-empty.
    - BLOCKED→RUN on out_ready.
    - RUN→EMPTY when the last result drains.
  - The FSM is internal. A bench probes it hierarchically.
- Data passes through unchanged. No arithmetic beyond pointer, count and tag increments.

## Timing
- **Reset** (async assert, sync release): `in_ready=1`, `alu_en=0`, `alu_opcode/a/b=0`, `out_valid=0`, `out_result=0`, `out_opcode=0`, `out_tag=0`, `count=0`, tag counter 0, FSM=EMPTY.
- **Reset mid-operation:** FIFO contents and the pending result are discarded, with no partial output.
- **Latency (no bypass):** a request accepted at edge k issues in cycle k→k+1, and `out_valid` rises after edge k+1. This is 2 edges.
- **Throughput:** 1 result per cycle while `out_ready=1` and `in_valid=1`.
- **Handshake rule:** `out_*` must not change while `out_valid && !out_ready`.

## Configuration
- Macro: `ALU_ISSUE_BYPASS_EN`.
- **Defined:** when `count == 0` and `in_valid` is high and the slot is free or draining, the input is issued directly to the ALU in the same cycle. `alu_en=1`, operands come from `in_*`, and the request is not written to the FIFO. Latency is 1 edge. `in_ready` is unchanged.
- **Undefined:** all requests pass through the FIFO, with 2-edge minimum latency.

## Test plan
The bench uses a stub ALU: `alu_result = alu_a + alu_b + alu_opcode`.
- **Reset:** check every output at reset value. Push opcode=000, A=6, B=5 → after 2 edges (1 with bypass): out_valid=1, out_result=11, out_opcode=000, out_tag=0.
- **Back-to-back:** push opcodes 000..111 with A=6, B=5 and out_ready=1 → results 11..18 in order, tags 0..7, one per cycle after the first.
- **Full:** hold out_ready=0 and push 5 requests → slot holds the first, FIFO count=4, in_ready=0. The 6th push is refused and FSM=BLOCKED. Release out_ready → all 5 drain in order.
- **Same-edge push/pop:** at count=2 with in_valid=1 and an issue → count stays 2 and the pushed entry emerges 3rd.
- **Tag wrap:** issue 257 requests → 256th has out_tag=255, 257th has out_tag=0.
- **Reset mid-stream:** assert rst_n=0 with count=3 and out_valid=1 → immediately out_valid=0 and count=0. After release, the next request returns tag 0.
